// File: rtl/misr_checker_pkg.sv
// Shared BIST definitions: FSM state encoding and default
// signature parameters for the MISR response checker.
package misr_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         NBIT_DEF   = 4;
  localparam logic [3:0] TAPS_DEF   = 4'b1100;
  localparam logic [3:0] SEED_DEF   = 4'b0000;
  localparam int         NPAT_DEF   = 15;
  localparam logic [3:0] GOLDEN_DEF = 4'b1000;

endpackage

// File: rtl/misr_core.sv
// Signature register: async reset to SEED, with load, MISR
// step and serial scan shift (load > step > shift).
module misr_core #(
  parameter int              NBIT = 4,
  parameter logic [NBIT-1:0] TAPS = '0,
  parameter logic [NBIT-1:0] SEED = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            shift,
  input  logic [NBIT-1:0] resp,
  input  logic            scan_in,
  output logic [NBIT-1:0] sig
);

  logic fb;

  assign fb = ^(sig & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (step) begin
      sig <= {sig[NBIT-2:0], fb} ^ resp;
    end else if (shift) begin
      sig <= {sig[NBIT-2:0], scan_in};
    end
  end

endmodule

// File: rtl/misr_checker.sv
// MISR response checker: compacts NPAT responses, compares
// against GOLDEN, then allows serial scan-out of the signature.
module misr_checker
  import misr_checker_pkg::*;
#(
  parameter int              NBIT   = NBIT_DEF,
  parameter logic [NBIT-1:0] TAPS   = NBIT'(TAPS_DEF),
  parameter logic [NBIT-1:0] SEED   = NBIT'(SEED_DEF),
  parameter int              NPAT   = NPAT_DEF,
  parameter logic [NBIT-1:0] GOLDEN = NBIT'(GOLDEN_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            resp_valid,
  input  logic [NBIT-1:0] resp,
  input  logic            scan_en,
  input  logic            scan_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [NBIT-1:0] sig,
  output logic            scan_out
);

  localparam int CW = $clog2(NPAT + 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          pass_nxt;
  logic          load;
  logic          step;
  logic          shift;
  logic          last;

  assign last     = (count == CW'(NPAT - 1));
  assign scan_out = sig[NBIT-1];

  misr_core #(
    .NBIT (NBIT),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .shift   (shift),
    .resp    (resp),
    .scan_in (scan_in),
    .sig     (sig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      pass  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      pass  <= pass_nxt;
      busy  <= (state_nxt == RUN) ||
               (state_nxt == CHECK);
      done  <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pass_nxt  = pass;
    load      = 1'b0;
    step      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
          count_nxt = '0;
          pass_nxt  = 1'b0;
        end
      end
      RUN: begin
        // the final beat is compacted on the way into CHECK
        if (resp_valid) begin
          step      = 1'b1;
          count_nxt = count + CW'(1);
          if (last) state_nxt = CHECK;
        end
      end
      CHECK: begin
        pass_nxt  = (sig == GOLDEN);
        state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
          count_nxt = '0;
          pass_nxt  = 1'b0;
        end else if (scan_en) begin
          shift = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_misr_checker.sv
// Randomized scoreboard bench for misr_checker with an
// arithmetic signature model and a done-triggered monitor.
module tb_misr_checker;
  import misr_checker_pkg::*;

  localparam int NPAT = 15;

  typedef struct packed {
    logic [3:0] sig;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resp_valid;
  logic [3:0] resp;
  logic       scan_en;
  logic       scan_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] sig;
  logic       scan_out;

  int passed = 0;
  int total  = 0;

  exp_t       exp_q[$];
  logic [3:0] stim[$];
  exp_t       mon_e;
  logic       done_q = 1'b0;
  logic [3:0] scan_exp;

  always #5 clk = ~clk;

  misr_checker dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp_valid (resp_valid),
    .resp       (resp),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .sig        (sig),
    .scan_out   (scan_out)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // Signature as polynomial arithmetic: multiply by x mod 2^4,
  // add feedback parity, xor in the response word.
  function automatic exp_t model();
    int s;
    int fb;
    exp_t e;
    s = int'(SEED_DEF);
    foreach (stim[i]) begin
      fb = $countones(s & int'(TAPS_DEF)) % 2;
      s  = (((s * 2) % 16) + fb) ^ int'(stim[i]);
    end
    e.sig  = s[3:0];
    e.pass = (s == int'(GOLDEN_DEF));
    return e;
  endfunction

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_sig", 32'(sig), 32'(mon_e.sig));
        chk("mon_pass", 32'(pass), 32'(mon_e.pass));
      end
    end
    done_q = done;
  end

  task automatic set_test2();
    stim.delete();
    stim.push_back(4'b0001);
    for (int i = 1; i < NPAT; i++) stim.push_back(4'b0000);
  endtask

  // gap: 0 none, 1 every other cycle, 2 random
  task automatic run(input int gap, input int start_at,
                     input bit extra, input bit skip_start);
    exp_t e;
    e = model();
    exp_q.push_back(e);
    if (!skip_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    foreach (stim[i]) begin
      if ((gap == 1 && i > 0) ||
          (gap == 2 && $urandom_range(0, 1) == 1)) begin
        resp_valid = 1'b0;
        resp       = 4'($urandom);
        @(posedge clk); #1;
      end
      resp_valid = 1'b1;
      resp       = stim[i];
      start      = (i == start_at);
      @(posedge clk); #1;
    end
    start      = 1'b0;
    resp_valid = extra;
    resp       = 4'($urandom_range(1, 15));
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_done0", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("lat_done1", 32'(done), 32'd1);
    chk("busy_clr", 32'(busy), 32'd0);
    if (extra) begin
      resp = 4'($urandom_range(1, 15));
      @(posedge clk); #1;
      chk("extra_sig", 32'(sig), 32'(e.sig));
    end
    resp_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp       = '0;
    scan_en    = 1'b0;
    scan_in    = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_sig", 32'(sig), 32'(SEED_DEF));
    chk("rst_so", 32'(scan_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    stim.delete();
    for (int i = 0; i < NPAT; i++) stim.push_back(4'b0000);
    run(0, -1, 1'b0, 1'b0);
    chk("t1_sig", 32'(sig), 32'h0);
    chk("t1_pass", 32'(pass), 32'd0);

    set_test2();
    run(0, -1, 1'b0, 1'b0);
    chk("t2_sig", 32'(sig), 32'h8);
    chk("t2_pass", 32'(pass), 32'd1);

    scan_exp = 4'b1000;
    scan_en  = 1'b1;
    scan_in  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("scan_out", 32'(scan_out), 32'(scan_exp[3-k]));
      @(posedge clk); #1;
    end
    scan_en = 1'b0;
    chk("scan_sig", 32'(sig), 32'hF);
    chk("scan_pass", 32'(pass), 32'd1);
    chk("scan_done", 32'(done), 32'd1);

    set_test2();
    run(1, -1, 1'b1, 1'b0);
    chk("t3_sig", 32'(sig), 32'h8);
    chk("t3_pass", 32'(pass), 32'd1);

    start   = 1'b1;
    scan_en = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    scan_en = 1'b0;
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_sig", 32'(sig), 32'(SEED_DEF));
    chk("t6_pass", 32'(pass), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    set_test2();
    run(0, 5, 1'b0, 1'b1);
    chk("t6_pass_end", 32'(pass), 32'd1);

    set_test2();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      resp_valid = 1'b1;
      resp       = stim[i];
      @(posedge clk); #1;
    end
    resp_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_sig", 32'(sig), 32'(SEED_DEF));
    chk("t5_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run(0, -1, 1'b0, 1'b0);
    chk("t5_pass", 32'(pass), 32'd1);

    for (int r = 0; r < 8; r++) begin
      stim.delete();
      for (int i = 0; i < NPAT; i++)
        stim.push_back(4'($urandom));
      run(2, -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    @(posedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
